// File: rtl/zeroriscy_csr_access_arb.sv
// -----------------------------------------------------------------------------
// zeroriscy_csr_access_arb
//
// Shares the single SRAM-like CSR file port between the core ID stage and a
// debug/host master.
//  - Core accesses pass straight through with no latency.
//  - A debug access is granted for one cycle (IDLE -> RESP). Its read data is
//    registered and returned with a one-cycle dbg_rvalid_o pulse.
//  - A 4-bit starvation counter forces a pending debug request through after
//    STARVE_LIMIT consecutive losses to the core.
//  - No debug grant is given while the exception controller saves or restores
//    trap state (excp_busy_i).
//
// Optional feature macro: CSR_ARB_DBG_WRITE_EN
//  - Defined: debug writes issue CSR_OP_WRITE, and dbg_err_o stays 0.
//  - Undefined (default): debug accesses always issue CSR_OP_NONE. A granted
//    write is reported through dbg_err_o together with dbg_rvalid_o.
//
// Ports:
//  clk, rst_n           clock, synchronous active-low reset
//  core_csr_*_i/_o      core request (access/addr/wdata/op), rdata, stall
//  dbg_*_i/_o           debug request/we/addr/wdata, gnt, rvalid, rdata, err
//  excp_busy_i          trap save/restore in progress, which blocks debug
//  csr_*_o, csr_rdata_i CSR file port
// -----------------------------------------------------------------------------
module zeroriscy_csr_access_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_csr_access_i,
  input  logic [11:0] core_csr_addr_i,
  input  logic [31:0] core_csr_wdata_i,
  input  logic [1:0]  core_csr_op_i,
  output logic [31:0] core_csr_rdata_o,
  output logic        core_csr_stall_o,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [11:0] dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  output logic        dbg_gnt_o,
  output logic        dbg_rvalid_o,
  output logic [31:0] dbg_rdata_o,
  output logic        dbg_err_o,
  input  logic        excp_busy_i,
  output logic        csr_access_o,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_wdata_o,
  output logic [1:0]  csr_op_o,
  input  logic [31:0] csr_rdata_i
);

  localparam logic [1:0] CSR_OP_NONE  = 2'd0;
  localparam logic [1:0] CSR_OP_WRITE = 2'd1;
  localparam logic [3:0] LP_LIMIT     = 4'(STARVE_LIMIT);

  typedef enum logic {ST_IDLE, ST_RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_starve_cnt;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_grant;
  logic        w_starved;
  logic [1:0]  w_dbg_op;
  logic        w_dbg_err;

`ifdef CSR_ARB_DBG_WRITE_EN
  assign w_dbg_op  = dbg_we_i ? CSR_OP_WRITE : CSR_OP_NONE;
  assign w_dbg_err = 1'b0;
`else
  // Writes are suppressed. The read still happens, and the drop is flagged.
  assign w_dbg_op  = CSR_OP_NONE;
  assign w_dbg_err = dbg_we_i;
`endif

  assign w_starved = (r_starve_cnt == LP_LIMIT);

  // Qualifying with rst_n keeps the grant and the stall low during reset.
  assign w_grant = rst_n & (r_state == ST_IDLE) & dbg_req_i & ~excp_busy_i &
                   (~core_csr_access_i | w_starved);

  // Port mux: debug owns the port only in the grant cycle.
  assign csr_access_o     = w_grant ? 1'b1        : core_csr_access_i;
  assign csr_addr_o       = w_grant ? dbg_addr_i  : core_csr_addr_i;
  assign csr_wdata_o      = w_grant ? dbg_wdata_i : core_csr_wdata_i;
  assign csr_op_o         = w_grant ? w_dbg_op    : core_csr_op_i;
  assign core_csr_rdata_o = w_grant ? 32'd0       : csr_rdata_i;
  assign core_csr_stall_o = w_grant & core_csr_access_i;

  assign dbg_gnt_o    = w_grant;
  assign dbg_rvalid_o = r_rvalid;
  assign dbg_rdata_o  = r_rdata;
  assign dbg_err_o    = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= 4'd0;
      r_rvalid     <= 1'b0;
      r_rdata      <= 32'd0;
      r_err        <= 1'b0;
    end else begin
      r_rvalid <= w_grant;
      r_err    <= w_grant & w_dbg_err;
      if (w_grant) begin
        r_rdata <= csr_rdata_i;
      end

      case (r_state)
        ST_IDLE: if (w_grant) r_state <= ST_RESP;
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      // Losses are counted only in IDLE with no trap activity. In that case a
      // non-granted pending request means the core took the port.
      if (w_grant || !dbg_req_i) begin
        r_starve_cnt <= 4'd0;
      end else if (r_state == ST_IDLE && !excp_busy_i && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_zeroriscy_csr_access_arb.sv
// -----------------------------------------------------------------------------
// Directed testbench for zeroriscy_csr_access_arb (STARVE_LIMIT = 4).
// A small CSR-file model provides csr_rdata_i from csr_addr_o.
// Inputs change on the falling edge. Outputs are checked 1 time unit later.
// -----------------------------------------------------------------------------
module tb_zeroriscy_csr_access_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_csr_access_i;
  logic [11:0] core_csr_addr_i;
  logic [31:0] core_csr_wdata_i;
  logic [1:0]  core_csr_op_i;
  logic [31:0] core_csr_rdata_o;
  logic        core_csr_stall_o;
  logic        dbg_req_i;
  logic        dbg_we_i;
  logic [11:0] dbg_addr_i;
  logic [31:0] dbg_wdata_i;
  logic        dbg_gnt_o;
  logic        dbg_rvalid_o;
  logic [31:0] dbg_rdata_o;
  logic        dbg_err_o;
  logic        excp_busy_i;
  logic        csr_access_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_wdata_o;
  logic [1:0]  csr_op_o;
  logic [31:0] csr_rdata_i;

  int n_checks = 0;
  int n_errors = 0;

`ifdef CSR_ARB_DBG_WRITE_EN
  localparam logic [31:0] EXP_WR_OP  = 32'd1;
  localparam logic [31:0] EXP_WR_ERR = 32'd0;
`else
  localparam logic [31:0] EXP_WR_OP  = 32'd0;
  localparam logic [31:0] EXP_WR_ERR = 32'd1;
`endif

  always #5 clk = ~clk;

  zeroriscy_csr_access_arb #(.STARVE_LIMIT(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .core_csr_access_i (core_csr_access_i),
    .core_csr_addr_i   (core_csr_addr_i),
    .core_csr_wdata_i  (core_csr_wdata_i),
    .core_csr_op_i     (core_csr_op_i),
    .core_csr_rdata_o  (core_csr_rdata_o),
    .core_csr_stall_o  (core_csr_stall_o),
    .dbg_req_i         (dbg_req_i),
    .dbg_we_i          (dbg_we_i),
    .dbg_addr_i        (dbg_addr_i),
    .dbg_wdata_i       (dbg_wdata_i),
    .dbg_gnt_o         (dbg_gnt_o),
    .dbg_rvalid_o      (dbg_rvalid_o),
    .dbg_rdata_o       (dbg_rdata_o),
    .dbg_err_o         (dbg_err_o),
    .excp_busy_i       (excp_busy_i),
    .csr_access_o      (csr_access_o),
    .csr_addr_o        (csr_addr_o),
    .csr_wdata_o       (csr_wdata_o),
    .csr_op_o          (csr_op_o),
    .csr_rdata_i       (csr_rdata_i)
  );

  // CSR file model. mepc (0x341) holds 0x1234, and every other address reads
  // a pattern built from the address.
  function automatic logic [31:0] csr_model(input logic [11:0] a);
    if (a == 12'h341) return 32'h0000_1234;
    return {20'hABCDE, a};
  endfunction

  assign csr_rdata_i = csr_model(csr_addr_o);

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- reset ----------------
    rst_n = 1'b0;
    core_csr_access_i = 1'b1; core_csr_addr_i = 12'h305;
    core_csr_wdata_i = 32'h0; core_csr_op_i = 2'd0;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 12'h341; dbg_wdata_i = 32'h0;
    excp_busy_i = 1'b0;
    @(negedge clk); #1;
    check_val("rst_gnt",   32'(dbg_gnt_o), 32'd0);
    check_val("rst_stall", 32'(core_csr_stall_o), 32'd0);
    @(negedge clk); #1;
    check_val("rst_rvalid", 32'(dbg_rvalid_o), 32'd0);
    check_val("rst_rdata",  dbg_rdata_o, 32'd0);
    check_val("rst_err",    32'(dbg_err_o), 32'd0);
    $display("reset checked");
    @(negedge clk);
    dbg_req_i = 1'b0; core_csr_access_i = 1'b0;
    rst_n = 1'b1;

    // ---------------- core pass-through ----------------
    @(negedge clk);
    core_csr_access_i = 1'b1; core_csr_addr_i = 12'h344;
    core_csr_wdata_i = 32'h55; core_csr_op_i = 2'd3;
    #1;
    check_val("pt_access", 32'(csr_access_o), 32'd1);
    check_val("pt_addr",   32'(csr_addr_o), 32'h344);
    check_val("pt_wdata",  csr_wdata_o, 32'h55);
    check_val("pt_op",     32'(csr_op_o), 32'd3);
    check_val("pt_rdata",  core_csr_rdata_o, 32'hABCDE344);
    check_val("pt_stall",  32'(core_csr_stall_o), 32'd0);
    $display("core pass-through checked");

    // ---------------- debug read of mepc ----------------
    @(negedge clk);
    core_csr_access_i = 1'b0;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 12'h341;
    #1;
    check_val("rd_gnt",    32'(dbg_gnt_o), 32'd1);
    check_val("rd_access", 32'(csr_access_o), 32'd1);
    check_val("rd_addr",   32'(csr_addr_o), 32'h341);
    check_val("rd_op",     32'(csr_op_o), 32'd0);
    check_val("rd_crdata", core_csr_rdata_o, 32'd0);
    @(negedge clk);
    dbg_req_i = 1'b0;
    #1;
    check_val("rd_rvalid", 32'(dbg_rvalid_o), 32'd1);
    check_val("rd_rdata",  dbg_rdata_o, 32'h0000_1234);
    check_val("rd_gnt_n1", 32'(dbg_gnt_o), 32'd0);
    @(negedge clk); #1;
    check_val("rd_rvalid_off", 32'(dbg_rvalid_o), 32'd0);
    check_val("rd_rdata_hold", dbg_rdata_o, 32'h0000_1234);
    $display("debug read transaction checked");

    // ---------------- starvation ----------------
    @(negedge clk);
    core_csr_access_i = 1'b1; core_csr_addr_i = 12'h305; core_csr_op_i = 2'd2;
    dbg_req_i = 1'b1; dbg_addr_i = 12'h340;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val($sformatf("stv_gnt%0d", i), 32'(dbg_gnt_o), 32'd0);
      check_val($sformatf("stv_addr%0d", i), 32'(csr_addr_o), 32'h305);
      @(negedge clk);
    end
    #1;
    check_val("stv_gnt",   32'(dbg_gnt_o), 32'd1);
    check_val("stv_stall", 32'(core_csr_stall_o), 32'd1);
    check_val("stv_addr",  32'(csr_addr_o), 32'h340);
    @(negedge clk);
    dbg_req_i = 1'b0;
    #1;
    check_val("stv_resp_rvalid", 32'(dbg_rvalid_o), 32'd1);
    check_val("stv_resp_rdata",  dbg_rdata_o, 32'hABCDE340);
    check_val("stv_resp_stall",  32'(core_csr_stall_o), 32'd0);
    check_val("stv_resp_addr",   32'(csr_addr_o), 32'h305);
    $display("starvation transaction checked");

    // ---------------- debug write ----------------
    @(negedge clk);
    core_csr_access_i = 1'b0;
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 12'h300; dbg_wdata_i = 32'h8;
    #1;
    check_val("wr_gnt",   32'(dbg_gnt_o), 32'd1);
    check_val("wr_op",    32'(csr_op_o), EXP_WR_OP);
    check_val("wr_wdata", csr_wdata_o, 32'h8);
    @(negedge clk);
    dbg_req_i = 1'b0; dbg_we_i = 1'b0;
    #1;
    check_val("wr_rvalid", 32'(dbg_rvalid_o), 32'd1);
    check_val("wr_err",    32'(dbg_err_o), EXP_WR_ERR);
    @(negedge clk); #1;
    check_val("wr_err_off", 32'(dbg_err_o), 32'd0);
    $display("debug write transaction checked");

    // ---------------- excp_busy blocks debug ----------------
    @(negedge clk);
    excp_busy_i = 1'b1; dbg_req_i = 1'b1; dbg_addr_i = 12'h341;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val($sformatf("busy_gnt%0d", i), 32'(dbg_gnt_o), 32'd0);
      @(negedge clk);
    end
    excp_busy_i = 1'b0;
    #1;
    check_val("busy_release_gnt", 32'(dbg_gnt_o), 32'd1);
    @(negedge clk);
    dbg_req_i = 1'b0;
    $display("excp_busy transaction checked");

    // ---------------- counter holds while busy ----------------
    // Two losses bring the count to 2. The count must still be 2 after three
    // busy cycles, so two more losses lead to the grant.
    @(negedge clk);
    core_csr_access_i = 1'b1; dbg_req_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1; check_val($sformatf("hold_pre%0d", i), 32'(dbg_gnt_o), 32'd0);
      @(negedge clk);
    end
    excp_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; check_val($sformatf("hold_busy%0d", i), 32'(dbg_gnt_o), 32'd0);
      @(negedge clk);
    end
    excp_busy_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1; check_val($sformatf("hold_post%0d", i), 32'(dbg_gnt_o), 32'd0);
      @(negedge clk);
    end
    #1;
    check_val("hold_gnt", 32'(dbg_gnt_o), 32'd1);
    @(negedge clk);
    dbg_req_i = 1'b0; core_csr_access_i = 1'b0;
    $display("starve counter hold checked");

    // ---------------- reset during RESP ----------------
    @(negedge clk);
    dbg_req_i = 1'b1; dbg_addr_i = 12'h341;
    #1;
    check_val("rr_gnt", 32'(dbg_gnt_o), 32'd1);
    @(negedge clk);
    dbg_req_i = 1'b0; rst_n = 1'b0;
    #1;
    check_val("rr_in_resp", 32'(dbg_rvalid_o), 32'd1);
    @(negedge clk); #1;
    check_val("rr_rvalid", 32'(dbg_rvalid_o), 32'd0);
    check_val("rr_rdata",  dbg_rdata_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    dbg_req_i = 1'b1;
    #1;
    check_val("rr_idle_gnt", 32'(dbg_gnt_o), 32'd1);
    @(negedge clk);
    dbg_req_i = 1'b0;
    $display("reset during RESP checked");

    // ---------------- continuous debug requests ----------------
    @(negedge clk);
    dbg_req_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_val($sformatf("b2b_gnt%0d", i),    32'(dbg_gnt_o),    32'((i % 2) == 0));
      check_val($sformatf("b2b_rvalid%0d", i), 32'(dbg_rvalid_o), 32'((i % 2) == 1));
      @(negedge clk);
    end
    dbg_req_i = 1'b0;
    $display("back-to-back grants checked");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/zeroriscy_csr_access_arb.md
# zeroriscy_csr_access_arb

Arbiter that shares the single SRAM-like port of the control and status register file between the core's ID stage and a debug/host master. Core accesses pass through combinationally. Debug accesses get a one-cycle grant with a registered response. A starvation counter guarantees forward progress for debug under continuous core CSR traffic. Accesses are blocked while the exception controller is saving or restoring trap state.

## Interface

Parameters:
- STARVE_LIMIT, default 4: consecutive cycles a pending debug request may lose to the core before it is forced through. Legal range 1..15.

Ports (reset is synchronous, active-low; one clock):
- clk  in  1  core clock; all state updates on its rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- core_csr_access_i  in  1  core requests the CSR port this cycle
- core_csr_addr_i  in  12  core CSR address
- core_csr_wdata_i  in  32  core write data
- core_csr_op_i  in  2  core CSR op (CSR_OP_NONE/WRITE/SET/CLEAR)
- core_csr_rdata_o  out  32  read data to core; valid when core owns the port
- core_csr_stall_o  out  1  core request not served this cycle; core holds its request
- dbg_req_i  in  1  debug request; held until dbg_gnt_o
- dbg_we_i  in  1  debug write (1) or read (0)
- dbg_addr_i  in  12  debug CSR address
- dbg_wdata_i  in  32  debug write data
- dbg_gnt_o  out  1  debug access performed this cycle
- dbg_rvalid_o  out  1  one-cycle pulse, response valid
- dbg_rdata_o  out  32  registered read data of the granted access
- dbg_err_o  out  1  pulses with dbg_rvalid_o when a write was dropped
- excp_busy_i  in  1  csr_save_cause or csr_restore_mret active; debug must not be granted
- csr_access_o  out  1  to CSR file
- csr_addr_o  out  12  to CSR file
- csr_wdata_o  out  32  to CSR file
- csr_op_o  out  2  to CSR file
- csr_rdata_i  in  32  combinational read data from CSR file

## Operation

- State machine states are IDLE and RESP.
- Debug grant condition (combinational, IDLE only): dbg_req_i & ~excp_busy_i & (~core_csr_access_i | starve_cnt == STARVE_LIMIT).
- Grant cycle behaviour:
  - The port carries the debug access: csr_access_o=1, dbg address and data.
  - csr_op_o = dbg_we_i ? CSR_OP_WRITE : CSR_OP_NONE.
  - csr_rdata_i is captured into dbg_rdata_o.
  - The state moves to RESP.
  - core_csr_stall_o = core_csr_access_i.
- RESP lasts exactly one cycle:
  - dbg_rvalid_o=1, then the state returns to IDLE.
  - Debug is never granted in RESP; the core owns the port.
- Non-grant cycles: the port mirrors the core inputs, core_csr_rdata_o = csr_rdata_i, and core_csr_stall_o=0.
- core_csr_rdata_o is 0 in grant cycles.
- starve_cnt is 4 bits wide and updates as follows:
  - Cleared on a grant, or when dbg_req_i=0.
  - Incremented when dbg_req_i=1 and the core wins in IDLE, saturating at STARVE_LIMIT.
  - Held in RESP and while excp_busy_i=1.
- When excp_busy_i=1:
  - The core still passes through.
  - A pending debug request waits and starve_cnt holds.

## Timing

- Core path has zero latency; it is purely combinational through the arbiter.
- Debug: dbg_gnt_o is in cycle N, dbg_rvalid_o and dbg_rdata_o in N+1.
- Back-to-back debug grants occur at most every 2 cycles.
- dbg_rdata_o holds its value until the next grant.
- Reset values: state IDLE, starve_cnt 0, dbg_rvalid_o 0, dbg_rdata_o 0, dbg_err_o 0. dbg_gnt_o and core_csr_stall_o are 0 while rst_n=0.
- Reset asserted in RESP: the state returns to IDLE with no rvalid pulse.
- dbg_req_i dropped before grant: no access, counter cleared.

## Configuration

- CSR_ARB_DBG_WRITE_EN defined: debug writes issue CSR_OP_WRITE; dbg_err_o is always 0.
- CSR_ARB_DBG_WRITE_EN undefined: debug accesses always issue CSR_OP_NONE, and read data is still returned.
  - A granted access with dbg_we_i=1 pulses dbg_err_o together with dbg_rvalid_o.

## Test plan

- Debug read of 12'h341 with mepc=32'h0000_1234 and no core traffic -> dbg_gnt_o at N, dbg_rvalid_o at N+1, dbg_rdata_o=32'h0000_1234, csr_op_o=CSR_OP_NONE at N.
- Core holds csr access every cycle with dbg_req_i=1, STARVE_LIMIT=4 -> core wins 4 cycles, grant in 5th with core_csr_stall_o=1, core served again in the following cycle.
- Debug write 32'h8 to 12'h300 with macro defined -> csr_op_o=CSR_OP_WRITE, dbg_err_o=0. With macro undefined -> csr_op_o=CSR_OP_NONE, dbg_err_o=1 at N+1.
- excp_busy_i=1 for 3 cycles with debug pending and no core access -> no grant and starve_cnt held; grant in the first cycle excp_busy_i=0.
- rst_n=0 in the RESP cycle -> dbg_rvalid_o=0 next cycle, state IDLE, dbg_rdata_o=0.
- dbg_req_i held high continuously -> grants spaced exactly 2 cycles apart, one rvalid per grant.
